// File: rtl/polar_inverse_decoder.sv
`default_nettype none
// ============================================================================
// Module      : polar_inverse_decoder
// Description : Hard-decision inverse of the N-point polar transform; recovers
//               u_hat from a codeword and packs the info positions serially.
//               Optional macro FROZEN_CHECK_EN builds the frozen-bit check.
// Revision    : 1.0 - initial release
// ============================================================================
module polar_inverse_decoder #(
    parameter int N     = 256,
    parameter int LOG2N = 8,
    parameter int K     = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N-1:0]     c_i,
    input  logic [N-1:0]     frozen_mask_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [N-1:0]     u_hat_o,
    output logic [K-1:0]     info_bits_o,
    output logic [LOG2N:0]   k_count_o,
    output logic             len_err_o,
    output logic             frozen_err_o
);

    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int PW = $clog2(K + 1);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [PW-1:0]    c_K_PTR   = PW'(K);
    localparam logic [LOG2N:0]   c_K_CNT   = (LOG2N + 1)'(K);
    localparam logic [SW-1:0]    c_LAST_ST = SW'(LOG2N - 1);
    localparam logic [LOG2N-1:0] c_LAST_IX = LOG2N'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFORM = 2'd1,
        S_PACK  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     w_q, w_d, mask_q, mask_d, u_hat_q, u_hat_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [LOG2N-1:0] idx_q, idx_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [K-1:0]     info_q, info_d;
    logic [LOG2N:0]   k_q, k_d;
    logic             len_err_q, len_err_d, out_valid_q, out_valid_d;
    logic [N-1:0]     w_bitrev, w_stage;
`ifdef FROZEN_CHECK_EN
    logic             ferr_q, ferr_d;
`endif

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) r[b] = x[LOG2N-1-b];
        return r;
    endfunction

    always_comb begin
        w_bitrev = '0;
        for (int j = 0; j < N; j++) w_bitrev[j] = c_i[bitrev(LOG2N'(j))];
    end

    // One butterfly stage: the lower element of each pair absorbs its partner.
    always_comb begin
        w_stage = w_q;
        for (int s = 0; s < LOG2N; s++) begin
            if (stage_q == SW'(s)) begin
                for (int i = 0; i < N; i++) begin
                    if (((i >> s) & 1) == 0) w_stage[i] = w_q[i] ^ w_q[i | (1 << s)];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        mask_d      = mask_q;
        u_hat_d     = u_hat_q;
        stage_d     = stage_q;
        idx_d       = idx_q;
        wr_ptr_d    = wr_ptr_q;
        info_d      = info_q;
        k_d         = k_q;
        len_err_d   = len_err_q;
        out_valid_d = out_valid_q;
`ifdef FROZEN_CHECK_EN
        ferr_d      = ferr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    w_d      = w_bitrev;
                    mask_d   = frozen_mask_i;
                    stage_d  = '0;
                    idx_d    = '0;
                    wr_ptr_d = '0;
                    info_d   = '0;
                    k_d      = '0;
`ifdef FROZEN_CHECK_EN
                    ferr_d   = 1'b0;
`endif
                    state_d  = S_XFORM;
                end
            end
            S_XFORM: begin
                w_d     = w_stage;
                stage_d = stage_q + 1'b1;
                if (stage_q == c_LAST_ST) state_d = S_PACK;
            end
            S_PACK: begin
                if (!mask_q[idx_q]) begin
                    k_d = k_q + 1'b1;
                    if (wr_ptr_q < c_K_PTR) begin
                        info_d[wr_ptr_q[IW-1:0]] = w_q[idx_q];
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
`ifdef FROZEN_CHECK_EN
                ferr_d = ferr_q | (mask_q[idx_q] & w_q[idx_q]);
`endif
                idx_d = idx_q + 1'b1;
                if (idx_q == c_LAST_IX) begin
                    u_hat_d   = w_q;
                    len_err_d = (k_d != c_K_CNT);
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                // out_valid rises one cycle after entering DONE
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            w_q         <= '0;
            mask_q      <= '0;
            u_hat_q     <= '0;
            stage_q     <= '0;
            idx_q       <= '0;
            wr_ptr_q    <= '0;
            info_q      <= '0;
            k_q         <= '0;
            len_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FROZEN_CHECK_EN
            ferr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            mask_q      <= mask_d;
            u_hat_q     <= u_hat_d;
            stage_q     <= stage_d;
            idx_q       <= idx_d;
            wr_ptr_q    <= wr_ptr_d;
            info_q      <= info_d;
            k_q         <= k_d;
            len_err_q   <= len_err_d;
            out_valid_q <= out_valid_d;
`ifdef FROZEN_CHECK_EN
            ferr_q      <= ferr_d;
`endif
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = out_valid_q;
    assign u_hat_o     = u_hat_q;
    assign info_bits_o = info_q;
    assign k_count_o   = k_q;
    assign len_err_o   = len_err_q;
`ifdef FROZEN_CHECK_EN
    assign frozen_err_o = ferr_q;
`else
    assign frozen_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_polar_inverse_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_polar_inverse_decoder
// Description : Self-checking bench for polar_inverse_decoder using a
//               subset-sum polar encoder model and a queue-based pack model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_polar_inverse_decoder;

    localparam int N     = 256;
    localparam int LOG2N = 8;
    localparam int K     = 128;
    localparam int LAT   = LOG2N + N + 1;
`ifdef FROZEN_CHECK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0]   c_in, mask, u_hat;
    logic [K-1:0]   info_bits;
    logic [LOG2N:0] k_count;
    logic           len_err, frozen_err;

    int total = 0;
    int bad   = 0;
    logic [N-1:0] fixed_mask;

    polar_inverse_decoder #(.N(N), .LOG2N(LOG2N), .K(K)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .c_i          (c_in),
        .frozen_mask_i(mask),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .u_hat_o      (u_hat),
        .info_bits_o  (info_bits),
        .k_count_o    (k_count),
        .len_err_o    (len_err),
        .frozen_err_o (frozen_err)
    );

    always #5 clk = ~clk;

    function automatic int brev(input int x);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) r |= ((x >> b) & 1) << (LOG2N - 1 - b);
        return r;
    endfunction

    // x = u * F^(x)n : x[j] is the parity of u over all indices whose bits cover j
    function automatic logic [N-1:0] encode(input logic [N-1:0] u);
        logic [N-1:0] x, c;
        for (int j = 0; j < N; j++) begin
            x[j] = 1'b0;
            for (int i = 0; i < N; i++) if ((i & j) == j) x[j] ^= u[i];
        end
        for (int k = 0; k < N; k++) c[k] = x[brev(k)];
        return c;
    endfunction

    task automatic ref_model(input logic [N-1:0] u, input logic [N-1:0] m,
                             output logic [K-1:0] info, output logic [LOG2N:0] kc,
                             output logic le, output logic fe);
        int q[$];
        for (int i = 0; i < N; i++) if (!m[i]) q.push_back(i);
        info = '0;
        for (int k = 0; k < q.size() && k < K; k++) info[k] = u[q[k]];
        kc = q.size();
        le = (q.size() != K);
        fe = FCHK && ((u & m) != '0);
    endtask

    function automatic logic [N-1:0] rand_vec();
        logic [N-1:0] v;
        for (int w = 0; w < N / 32; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    task automatic start_frame(input logic [N-1:0] c, input logic [N-1:0] m);
        int t = 0;
        while (!in_ready && t < 1000) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL start_timeout in_ready=%0b required=1", in_ready);
        end
        c_in = c; mask = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 1000) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({in_ready, out_valid, len_err, frozen_err} !== 4'b1000 || u_hat !== '0
            || info_bits !== '0 || k_count !== '0) begin
            bad++;
            $display("FAIL reset in_ready=%0b out_valid=%0b k=%0d u=%h required in_ready=1 others=0",
                     in_ready, out_valid, k_count, u_hat);
        end
    endtask

    task automatic test_directed();
        int lat;
        logic [N-1:0] ones = '1;
        logic [N-1:0] low_frozen = {{(N-K){1'b0}}, {K{1'b1}}};
        logic [N-1:0] one0 = 1;
        logic [N-1:0] top = ones ^ (ones >> 1);
        logic [K-1:0] itop = {1'b1, {(K-1){1'b0}}};
        logic [K-1:0] i1 = 1;

        start_frame('0, low_frozen); wait_out(lat);
        total++;
        if (u_hat !== '0 || info_bits !== '0 || k_count !== 9'd128 || len_err !== 1'b0 || frozen_err !== 1'b0) begin
            bad++;
            $display("FAIL zero_cw u=%h info=%h k=%0d le=%0b fe=%0b required all zero k=128",
                     u_hat, info_bits, k_count, len_err, frozen_err);
        end
        release_out();

        start_frame(ones, low_frozen); wait_out(lat);
        total++;
        if (u_hat !== top || info_bits !== itop || frozen_err !== 1'b0 || len_err !== 1'b0) begin
            bad++;
            $display("FAIL ones_cw u=%h info=%h fe=%0b required u=%h info=%h fe=0",
                     u_hat, info_bits, frozen_err, top, itop);
        end
        release_out();

        start_frame(one0, ~one0); wait_out(lat);
        total++;
        if (u_hat !== one0 || info_bits !== i1 || k_count !== 9'd1 || len_err !== 1'b1) begin
            bad++;
            $display("FAIL unit_cw u=%h info=%h k=%0d le=%0b required u=1 info=1 k=1 le=1",
                     u_hat, info_bits, k_count, len_err);
        end
        release_out();

        start_frame(ones, ~one0); wait_out(lat);
        total++;
        if (frozen_err !== FCHK || u_hat !== top) begin
            bad++;
            $display("FAIL frozen_chk fe=%0b required=%0b u=%h", frozen_err, FCHK, u_hat);
        end
        release_out();
    endtask

    task automatic test_stall();
        int lat;
        logic [N-1:0] u = rand_vec();
        logic [N-1:0] su;
        logic [K-1:0] si;
        logic [LOG2N:0] sk;
        int errs = 0;
        start_frame(encode(u), fixed_mask); wait_out(lat);
        su = u_hat; si = info_bits; sk = k_count;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || u_hat !== su || info_bits !== si || k_count !== sk) errs++;
        end
        total++;
        if (errs != 0 || su !== u) begin
            bad++;
            $display("FAIL stall unstable_cycles=%0d required=0 u=%h required_u=%h", errs, su, u);
        end
        release_out();
        total++;
        if (!in_ready || out_valid) begin
            bad++;
            $display("FAIL stall_release in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
        u = rand_vec();
        start_frame(encode(u), fixed_mask); wait_out(lat);
        total++;
        if (u_hat !== u || lat != LAT) begin
            bad++;
            $display("FAIL after_stall u=%h required=%h lat=%0d", u_hat, u, lat);
        end
        release_out();
    endtask

    task automatic test_clear_on_accept();
        int lat;
        logic [N-1:0] u = rand_vec();
        logic [N-1:0] prev;
        start_frame(encode(u), fixed_mask); wait_out(lat);
        prev = u_hat;
        release_out();
        start_frame(encode(rand_vec()), fixed_mask);
        total++;
        if (info_bits !== '0 || k_count !== '0 || frozen_err !== 1'b0 || u_hat !== prev || prev !== u) begin
            bad++;
            $display("FAIL clear_on_accept info=%h k=%0d fe=%0b u=%h required info=0 k=0 fe=0 u=%h",
                     info_bits, k_count, frozen_err, u_hat, u);
        end
        wait_out(lat);
        release_out();
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [N-1:0] u;
        for (int p = 0; p < 2; p++) begin
            start_frame(encode(rand_vec()), fixed_mask);
            repeat (p == 0 ? 3 : 100) @(posedge clk);
            #1 rst = 1'b1;
            #2 rst = 1'b0;
            #1;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || u_hat !== '0) begin
                bad++;
                $display("FAIL reset_abort%0d out_valid=%0b in_ready=%0b required 0/1", p, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        u = rand_vec();
        start_frame(encode(u), fixed_mask); wait_out(lat);
        total++;
        if (u_hat !== u || lat != LAT) begin
            bad++;
            $display("FAIL post_reset u=%h required=%h lat=%0d", u_hat, u, lat);
        end
        release_out();
    endtask

    task automatic test_random(input int frames, input bit rand_mask);
        int lat;
        logic [N-1:0] u, m;
        logic [K-1:0] ei;
        logic [LOG2N:0] ek;
        logic el, ef;
        for (int f = 0; f < frames; f++) begin
            u = rand_vec();
            m = rand_mask ? (rand_vec() & rand_vec()) | (f[0] ? '0 : rand_vec()) : fixed_mask;
            ref_model(u, m, ei, ek, el, ef);
            start_frame(encode(u), m); wait_out(lat);
            total++;
            if (lat != LAT) begin
                bad++; $display("FAIL latency f=%0d got=%0d required=%0d", f, lat, LAT);
            end
            total++;
            if (u_hat !== u) begin
                bad++; $display("FAIL u_hat f=%0d got=%h required=%h", f, u_hat, u);
            end
            total++;
            if (info_bits !== ei) begin
                bad++; $display("FAIL info_bits f=%0d got=%h required=%h", f, info_bits, ei);
            end
            total++;
            if (k_count !== ek || len_err !== el || frozen_err !== ef) begin
                bad++;
                $display("FAIL flags f=%0d k=%0d le=%0b fe=%0b required k=%0d le=%0b fe=%0b",
                         f, k_count, len_err, frozen_err, ek, el, ef);
            end
            release_out();
        end
    endtask

    initial begin
        int perm[N];
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; c_in = '0; mask = '0;
        for (int i = 0; i < N; i++) perm[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            int j = $urandom_range(i, 0);
            int t = perm[i];
            perm[i] = perm[j]; perm[j] = t;
        end
        fixed_mask = '0;
        for (int i = 0; i < N - K; i++) fixed_mask[perm[i]] = 1'b1;
        #23 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_stall();
        test_clear_on_accept();
        test_reset_abort();
        test_random(12, 1'b1);
        test_random(180, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
